// File: rtl/regfile_read_port_unit_if.sv
// Register-file access bus between decode/writeback (master) and the register file (slave).
//   reg_write_i, write_register_i, write_data_i : write port driven by writeback
//   read_enN_i, read_registerN_i                : read requests from decode, ports 1 and 2
//   read_dataN_o, read_validN_o                 : registered read results, one cycle later
interface regfile_read_port_unit_if #(
    parameter int unsigned N_BITS    = 32,
    parameter int unsigned ADDR_BITS = 5
);
    logic                 reg_write_i;
    logic [ADDR_BITS-1:0] write_register_i;
    logic [N_BITS-1:0]    write_data_i;
    logic                 read_en1_i;
    logic [ADDR_BITS-1:0] read_register1_i;
    logic                 read_en2_i;
    logic [ADDR_BITS-1:0] read_register2_i;
    logic [N_BITS-1:0]    read_data1_o;
    logic                 read_valid1_o;
    logic [N_BITS-1:0]    read_data2_o;
    logic                 read_valid2_o;

    modport master (
        output reg_write_i, write_register_i, write_data_i,
        output read_en1_i, read_register1_i, read_en2_i, read_register2_i,
        input  read_data1_o, read_valid1_o, read_data2_o, read_valid2_o
    );

    modport slave (
        input  reg_write_i, write_register_i, write_data_i,
        input  read_en1_i, read_register1_i, read_en2_i, read_register2_i,
        output read_data1_o, read_valid1_o, read_data2_o, read_valid2_o
    );
endinterface

// File: rtl/regfile_read_port_unit.sv
// MIPS register file: one write port, two independent registered read ports
// with write-to-read bypass and a hardwired $zero.
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous, active-high; restores SP/GP init values, clears the rest
//   bus   : regfile_read_port_unit_if slave modport (write port, read requests, read results)
module regfile_read_port_unit #(
    parameter int unsigned       N_BITS    = 32,
    parameter int unsigned       ADDR_BITS = 5,
    parameter int unsigned       SP_INDEX  = 29,
    parameter logic [N_BITS-1:0] SP_INIT   = N_BITS'(32'h7FFF_EFFC),
    parameter int unsigned       GP_INDEX  = 28,
    parameter logic [N_BITS-1:0] GP_INIT   = N_BITS'(32'h1000_8000)
) (
    input  logic                     clk,
    input  logic                     reset,
    regfile_read_port_unit_if.slave  bus
);
    localparam int unsigned NUM_REGS = 2 ** ADDR_BITS;

    logic [N_BITS-1:0] regs [NUM_REGS];
    logic [N_BITS-1:0] rd_val1_c;
    logic [N_BITS-1:0] rd_val2_c;
    logic              wr_active_c;

    // $zero is never written, so the stored entry at index 0 stays 0
    assign wr_active_c = bus.reg_write_i && (bus.write_register_i != '0);

    // Register storage
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i == SP_INDEX)      regs[i] <= SP_INIT;
                else if (i == GP_INDEX) regs[i] <= GP_INIT;
                else                    regs[i] <= '0;
            end
        end else if (wr_active_c) begin
            regs[bus.write_register_i] <= bus.write_data_i;
        end
    end

    // Read operand selection: $zero first, then same-cycle writeback bypass, then storage
    always_comb begin
        rd_val1_c = regs[bus.read_register1_i];
        if (bus.read_register1_i == '0) begin
            rd_val1_c = '0;
        end else if (bus.reg_write_i && (bus.write_register_i == bus.read_register1_i)) begin
            rd_val1_c = bus.write_data_i;
        end
    end

    always_comb begin
        rd_val2_c = regs[bus.read_register2_i];
        if (bus.read_register2_i == '0) begin
            rd_val2_c = '0;
        end else if (bus.reg_write_i && (bus.write_register_i == bus.read_register2_i)) begin
            rd_val2_c = bus.write_data_i;
        end
    end

    // Registered read ports; data holds when no request is made
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.read_data1_o  <= '0;
            bus.read_valid1_o <= 1'b0;
            bus.read_data2_o  <= '0;
            bus.read_valid2_o <= 1'b0;
        end else begin
            bus.read_valid1_o <= bus.read_en1_i;
            bus.read_valid2_o <= bus.read_en2_i;
            if (bus.read_en1_i) bus.read_data1_o <= rd_val1_c;
            if (bus.read_en2_i) bus.read_data2_o <= rd_val2_c;
        end
    end
endmodule

// File: tb/tb_regfile_read_port_unit.sv
// Directed bench for regfile_read_port_unit: reset values, write/read, bypass,
// $zero handling, reset during traffic and a streaming read of r1..r31.
module tb_regfile_read_port_unit;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

    regfile_read_port_unit_if #(.N_BITS(32), .ADDR_BITS(5)) bus ();

    regfile_read_port_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_write_i      = 1'b0;
        bus.write_register_i = '0;
        bus.write_data_i     = '0;
        bus.read_en1_i       = 1'b0;
        bus.read_register1_i = '0;
        bus.read_en2_i       = 1'b0;
        bus.read_register2_i = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_v1", 32'(bus.read_valid1_o), 32'd0);
        check("rst_v2", 32'(bus.read_valid2_o), 32'd0);
        check("rst_d1", bus.read_data1_o, 32'h0);
        check("rst_d2", bus.read_data2_o, 32'h0);

        // SP / GP reset values
        reset = 1'b0;
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd29;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd28;
        tick();
        check("sp_d1", bus.read_data1_o, 32'h7FFF_EFFC);
        check("gp_d2", bus.read_data2_o, 32'h1000_8000);
        check("sp_v1", 32'(bus.read_valid1_o), 32'd1);
        check("gp_v2", 32'(bus.read_valid2_o), 32'd1);

        // Write r5, no reads: valid drops, data holds
        idle();
        bus.reg_write_i = 1'b1; bus.write_register_i = 5'd5; bus.write_data_i = 32'hDEAD_BEEF;
        tick();
        check("idle_v1", 32'(bus.read_valid1_o), 32'd0);
        check("hold_d1", bus.read_data1_o, 32'h7FFF_EFFC);

        idle();
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd5;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd5;
        tick();
        check("r5_d1", bus.read_data1_o, 32'hDEAD_BEEF);
        check("r5_d2", bus.read_data2_o, 32'hDEAD_BEEF);
        check("r5_v1", 32'(bus.read_valid1_o), 32'd1);
        idle();
        tick();
        check("r5_off_v1", 32'(bus.read_valid1_o), 32'd0);
        check("r5_off_v2", 32'(bus.read_valid2_o), 32'd0);
        check("r5_hold_d2", bus.read_data2_o, 32'hDEAD_BEEF);

        // Bypass on port 1, then stored value
        bus.reg_write_i = 1'b1; bus.write_register_i = 5'd7; bus.write_data_i = 32'h0000_1234;
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd7;
        tick();
        check("byp_d1", bus.read_data1_o, 32'h0000_1234);
        idle();
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd7;
        tick();
        check("r7_stored", bus.read_data1_o, 32'h0000_1234);

        // $zero: write ignored, reads 0 during and after
        idle();
        bus.reg_write_i = 1'b1; bus.write_register_i = 5'd0; bus.write_data_i = 32'hFFFF_FFFF;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd0;
        tick();
        check("r0_byp_d2", bus.read_data2_o, 32'h0);
        check("r0_byp_v2", 32'(bus.read_valid2_o), 32'd1);
        idle();
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd0;
        tick();
        check("r0_next_d2", bus.read_data2_o, 32'h0);

        // Both ports bypass the same index
        idle();
        bus.reg_write_i = 1'b1; bus.write_register_i = 5'd9; bus.write_data_i = 32'h0000_A5A5;
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd9;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd9;
        tick();
        check("r9_byp_d1", bus.read_data1_o, 32'h0000_A5A5);
        check("r9_byp_d2", bus.read_data2_o, 32'h0000_A5A5);

        // Reset during back-to-back reads with a concurrent write
        idle();
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd5;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd5;
        tick();
        check("pre_rst_d1", bus.read_data1_o, 32'hDEAD_BEEF);
        reset = 1'b1;
        bus.reg_write_i = 1'b1; bus.write_register_i = 5'd5; bus.write_data_i = 32'h1111_1111;
        tick();
        check("mid_rst_v1", 32'(bus.read_valid1_o), 32'd0);
        check("mid_rst_v2", 32'(bus.read_valid2_o), 32'd0);
        check("mid_rst_d1", bus.read_data1_o, 32'h0);
        check("mid_rst_d2", bus.read_data2_o, 32'h0);
        reset = 1'b0;
        idle();
        bus.read_en1_i = 1'b1; bus.read_register1_i = 5'd5;
        bus.read_en2_i = 1'b1; bus.read_register2_i = 5'd29;
        tick();
        check("post_rst_r5", bus.read_data1_o, 32'h0);
        check("post_rst_v1", 32'(bus.read_valid1_o), 32'd1);
        check("post_rst_sp", bus.read_data2_o, 32'h7FFF_EFFC);

        // Fill r1..r31 with their own index, then stream reads on port 1
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.reg_write_i = 1'b1; bus.write_register_i = 5'(i); bus.write_data_i = 32'(i);
            tick();
        end
        idle();
        for (int i = 1; i < 32; i++) begin
            bus.read_en1_i = 1'b1; bus.read_register1_i = 5'(i);
            tick();
            check($sformatf("stream_v1_%0d", i), 32'(bus.read_valid1_o), 32'd1);
            check($sformatf("stream_d1_%0d", i), bus.read_data1_o, 32'(i));
        end
        idle();
        tick();
        check("stream_end_v1", 32'(bus.read_valid1_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/regfile_read_port_unit.md
Name: regfile_read_port_unit

Overview:
Synchronous MIPS register file with one write port and two independent registered read ports, i.e. the read side that consumes the values stored by the per-register storage elements. Sits in the decode stage: the writeback stage drives the write port, and decode issues read requests that return operands one cycle later. Includes write-to-read bypass so a same-cycle writeback is visible to a concurrent read, and $zero is hardwired.

Parameters:
N_BITS, 32, data width of each register and read/write data.
ADDR_BITS, 5, register address width; register count = 2**ADDR_BITS.
SP_INDEX, 29, index of the stack pointer register.
SP_INIT, 32'h7FFF_EFFC, reset value of register SP_INDEX.
GP_INDEX, 28, index of the global pointer register.
GP_INIT, 32'h1000_8000, reset value of register GP_INDEX.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
reg_write_i  input  1  write enable for the write port.
write_register_i  input  ADDR_BITS  destination register index.
write_data_i  input  N_BITS  data to write.
read_en1_i  input  1  read request, port 1.
read_register1_i  input  ADDR_BITS  source index, port 1.
read_en2_i  input  1  read request, port 2.
read_register2_i  input  ADDR_BITS  source index, port 2.
read_data1_o  output  N_BITS  registered read data, port 1.
read_valid1_o  output  1  high for one cycle when read_data1_o carries a new result.
read_data2_o  output  N_BITS  registered read data, port 2.
read_valid2_o  output  1  high for one cycle when read_data2_o carries a new result.

Behaviour:
- One clock (clk); reset is synchronous and active-high; sampled only on the rising edge of clk.
- Reset (reset=1 at an edge): all registers cleared to 0, except register SP_INDEX = SP_INIT and register GP_INDEX = GP_INIT. read_data1_o = read_data2_o = 0; read_valid1_o = read_valid2_o = 0. Reset dominates: a write or read presented in the same cycle is dropped.
- Write: at an edge with reset=0 and reg_write_i=1, reg[write_register_i] <= write_data_i. Writes with write_register_i = 0 are ignored; reg[0] always reads 0.
- Read latency: 1 cycle. At an edge with read_enN_i=1, read_dataN_o <= value of reg[read_registerN_i] and read_validN_o <= 1. At an edge with read_enN_i=0, read_validN_o <= 0 and read_dataN_o holds its previous value.
- Read value selection, evaluated per port, in priority order:
  1. If read_registerN_i = 0, the value is 0, including when a write to index 0 is pending.
  2. If reg_write_i=1 and write_register_i = read_registerN_i, the value is write_data_i (bypass; new data, not stale).
  3. Otherwise the value is the stored reg[read_registerN_i].
- Both ports are fully independent. Both may read the same index in the same cycle, and both receive identical data, including bypassed data.
- No back-pressure: a request is accepted every cycle. Back-to-back reads produce back-to-back valid pulses, so valid stays high continuously.
- Reset mid-operation: a read requested in the cycle reset is asserted produces no valid pulse. The first read after reset deasserts returns reset values.
- Address width: indices cover the full 0..2**ADDR_BITS-1 range, so no out-of-range case exists.

Test Plan:
- Reset, then read r29 on port 1 and r28 on port 2 -> next cycle read_data1_o=32'h7FFF_EFFC, read_data2_o=32'h1000_8000, both valids=1.
- Write r5=32'hDEAD_BEEF. Next cycle read r5 on both ports -> both read_data=32'hDEAD_BEEF, valid 1 for one cycle. With en low the cycle after, valid=0 and data holds.
- Bypass: in the same cycle, write r7=32'h0000_1234 and read r7 on port 1, where stored r7=0 -> read_data1_o=32'h0000_1234 one cycle later.
- Write r0=32'hFFFF_FFFF while reading r0 on port 2 that cycle and the next -> read_data2_o=0 both times.
- Assert reset during back-to-back reads of r5=32'hDEAD_BEEF with a concurrent write -> at the next edge, valids=0 and data=0. After reset, reading r5 returns 0 and the write was dropped.
- Stream reads of r1..r31 on port 1 for 31 consecutive cycles after writing reg[i]=i -> valid stays high and the data sequence is 1..31 with 1-cycle latency.
